bram_dp: RTL and testbench

BRAM_DP -- requirements
Module: bram_dp

---
 rtl/bram_pkg.sv | 11 +
 rtl/bram_core.sv | 44 ++++
 rtl/bram_dp.sv | 123 ++++++++++++
 tb/tb_bram_dp.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/bram_pkg.sv
// Shared constants and helpers for the byte-enabled dual-port block RAM.
package bram_pkg;

  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

  function automatic int laneCount(input int dataW, input int byteW);
    return dataW / byteW;
  endfunction

endpackage

// File: rtl/bram_core.sv
// Storage array with byte-lane writes and a registered read port; no reset so it maps onto block RAM.
module bram_core
   import bram_pkg::*;
#(
   parameter int    DATA_W    = 16,
   parameter int    ADDR_W    = 13,
   parameter int    BYTE_W    = 8,
   parameter string INIT_FILE = ""
) (
   input  logic                                 clk_i,
   input  logic                                 wrEn_i,
   input  logic [laneCount(DATA_W, BYTE_W)-1:0] be_i,
   input  logic [ADDR_W-1:0]                    wrAddr_i,
   input  logic [DATA_W-1:0]                    wrData_i,
   input  logic                                 rdEn_i,
   input  logic [ADDR_W-1:0]                    rdAddr_i,
   output logic [DATA_W-1:0]                    rdData_o
);

   localparam int NB    = laneCount(DATA_W, BYTE_W);
   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] rdData_q;

   // Each enabled byte lane of the addressed word takes the matching lane of the write data.
   always_ff @(posedge clk_i) begin
      for (int i = 0; i < NB; i++) begin
         if (wrEn_i && be_i[i]) begin
            mem[wrAddr_i][i*BYTE_W +: BYTE_W] <= wrData_i[i*BYTE_W +: BYTE_W];
         end
      end
   end

   // The non-blocking write makes a same-address read see the pre-write word.
   always_ff @(posedge clk_i) begin
      if (rdEn_i) begin
         rdData_q <= mem[rdAddr_i];
      end
   end

   assign rdData_o = rdData_q;

endmodule

// File: rtl/bram_dp.sv
// Dual-port block RAM wrapper: read-during-write forwarding, optional output stage,
// read-valid tracking and asynchronous reset of the read pipeline.
module bram_dp #(
  parameter int    DATA_W    = 16,
  parameter int    ADDR_W    = 13,
  parameter int    BYTE_W    = 8,
  parameter int    OUT_REG   = 0,
  parameter int    RDW_NEW   = 0,
  parameter string INIT_FILE = ""
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wren_n,
  input  logic [DATA_W/BYTE_W-1:0]   be,
  input  logic [ADDR_W-1:0]          wraddress,
  input  logic [DATA_W-1:0]          data_in,
  input  logic                       oen_n,
  input  logic [ADDR_W-1:0]          rdaddress,
  output logic [DATA_W-1:0]          data_out,
  output logic                       rd_valid
);

  import bram_pkg::*;

  localparam int NB = laneCount(DATA_W, BYTE_W);

  logic              wrActive;
  logic              rdAccept;
  logic [DATA_W-1:0] coreWord;
  logic [DATA_W-1:0] mergedWord;
  logic [NB-1:0]     fwdMask_d;
  logic [NB-1:0]     fwdMask_q;
  logic [DATA_W-1:0] fwdData_q;
  logic              rdValid1_q;

  // Writes are suppressed while reset is held so memory survives a reset pulse.
  assign wrActive = !wren_n && !rst;
  assign rdAccept = !oen_n;

  bram_core #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .BYTE_W    (BYTE_W),
    .INIT_FILE (INIT_FILE)
  ) uCore (
    .clk_i    (clk),
    .wrEn_i   (wrActive),
    .be_i     (be),
    .wrAddr_i (wraddress),
    .wrData_i (data_in),
    .rdEn_i   (rdAccept),
    .rdAddr_i (rdaddress),
    .rdData_o (coreWord)
  );

  always_comb begin
    fwdMask_d = '0;
    if (RDW_NEW != bram_pkg::RDW_OLD && wrActive && (wraddress == rdaddress)) begin
      fwdMask_d = be;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdValid1_q <= 1'b0;
      fwdMask_q  <= '0;
      fwdData_q  <= '0;
    end else begin
      rdValid1_q <= rdAccept;
      if (rdAccept) begin
        fwdMask_q <= fwdMask_d;
        fwdData_q <= data_in;
      end
    end
  end

  // Lanes written in the accepting cycle replace the stale lanes of the stored word.
  always_comb begin
    mergedWord = coreWord;
    for (int i = 0; i < NB; i++) begin
      if (fwdMask_q[i]) begin
        mergedWord[i*BYTE_W +: BYTE_W] = fwdData_q[i*BYTE_W +: BYTE_W];
      end
    end
  end

  generate
    if (OUT_REG == 0) begin : gLat1
      logic [DATA_W-1:0] dataHold_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          dataHold_q <= '0;
        end else if (rdValid1_q) begin
          dataHold_q <= mergedWord;
        end
      end

      // Fresh data shows during the valid cycle, then the hold register keeps it.
      assign data_out = rdValid1_q ? mergedWord : dataHold_q;
      assign rd_valid = rdValid1_q;
    end else begin : gLat2
      logic [DATA_W-1:0] dataOut_q;
      logic              rdValid2_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          dataOut_q  <= '0;
          rdValid2_q <= 1'b0;
        end else begin
          rdValid2_q <= rdValid1_q;
          if (rdValid1_q) begin
            dataOut_q <= mergedWord;
          end
        end
      end

      assign data_out = dataOut_q;
      assign rd_valid = rdValid2_q;
    end
  endgenerate

endmodule

// File: tb/tb_bram_dp.sv
// Scoreboard bench: two bram_dp configurations (latency 1 / old-data and latency 2 / new-data)
// share one stimulus stream and are checked against a word-level memory model.
module tb_bram_dp;

  localparam int DW = 16;
  localparam int AW = 13;
  localparam int NDUT = 2;
  localparam int NWORDS = 16;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          wren_n;
  logic [1:0]    be;
  logic [AW-1:0] wraddress;
  logic [DW-1:0] data_in;
  logic          oen_n;
  logic [AW-1:0] rdaddress;
  logic [DW-1:0] dataOut0;
  logic [DW-1:0] dataOut1;
  logic          rdValid0;
  logic          rdValid1;

  int            checks = 0;
  int            errors = 0;
  int            cycle = 0;
  int            lat [NDUT] = '{1, 2};
  int            rdwNew [NDUT] = '{0, 1};
  exp_t          expQ [NDUT][$];
  logic [DW-1:0] lastOut [NDUT] = '{16'h0, 16'h0};
  logic [DW-1:0] refMem [NWORDS];

  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  bram_dp #(.OUT_REG(0), .RDW_NEW(0)) dutOld (
    .clk(clk), .rst(rst), .wren_n(wren_n), .be(be), .wraddress(wraddress),
    .data_in(data_in), .oen_n(oen_n), .rdaddress(rdaddress),
    .data_out(dataOut0), .rd_valid(rdValid0)
  );

  bram_dp #(.OUT_REG(1), .RDW_NEW(1)) dutNew (
    .clk(clk), .rst(rst), .wren_n(wren_n), .be(be), .wraddress(wraddress),
    .data_in(data_in), .oen_n(oen_n), .rdaddress(rdaddress),
    .data_out(dataOut1), .rd_valid(rdValid1)
  );

  // Word a reader should see: the stored word, with written lanes taken from the
  // incoming data when the configuration returns new data on a collision.
  function automatic logic [DW-1:0] refRead(input int d, input logic wr, input logic [1:0] b,
                                            input int wa, input logic [DW-1:0] wd, input int ra);
    logic [DW-1:0] w;
    w = refMem[ra];
    if (rdwNew[d] != 0 && wr && wa == ra) begin
      for (int i = 0; i < 2; i++) begin
        if (b[i]) w[i*8 +: 8] = wd[i*8 +: 8];
      end
    end
    return w;
  endfunction

  task automatic checkOutput(input string name, input int d, input logic [31:0] act,
                             input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s dut%0d cycle %0d actual=%h required=%h", name, d, cycle, act, req);
    end
  endtask

  task automatic flushQueues();
    for (int d = 0; d < NDUT; d++) expQ[d].delete();
  endtask

  task automatic applyStimulus(input logic wr, input logic [1:0] b, input int wa,
                               input logic [DW-1:0] wd, input logic rd, input int ra);
    exp_t e;
    wren_n    = !wr;
    be        = b;
    wraddress = AW'(wa);
    data_in   = wd;
    oen_n     = !rd;
    rdaddress = AW'(ra);
    if (rd && !rst) begin
      for (int d = 0; d < NDUT; d++) begin
        e.data = refRead(d, wr, b, wa, wd, ra);
        e.due  = cycle + lat[d];
        expQ[d].push_back(e);
      end
    end
    @(posedge clk);
    if (wr && !rst) begin
      for (int i = 0; i < 2; i++) begin
        if (b[i]) refMem[wa][i*8 +: 8] = wd[i*8 +: 8];
      end
    end
    @(negedge clk);
    wren_n = 1'b1;
    oen_n  = 1'b1;
  endtask

  task automatic checkDut(input int d);
    logic          v;
    logic [DW-1:0] out;
    exp_t          e;
    v   = (d == 0) ? rdValid0 : rdValid1;
    out = (d == 0) ? dataOut0 : dataOut1;
    if (rst) begin
      checkOutput("rst_valid", d, 32'(v), 32'd0);
      checkOutput("rst_data", d, 32'(out), 32'd0);
      lastOut[d] = '0;
    end else begin
      while (expQ[d].size() > 0 && expQ[d][0].due < cycle) begin
        e = expQ[d].pop_front();
        checkOutput("missing_valid", d, 32'd0, 32'd1);
      end
      if (v) begin
        if (expQ[d].size() == 0) begin
          checkOutput("unexpected_valid", d, 32'd1, 32'd0);
        end else begin
          e = expQ[d].pop_front();
          checkOutput("valid_cycle", d, 32'(cycle), 32'(e.due));
          checkOutput("read_data", d, 32'(out), 32'(e.data));
        end
        lastOut[d] = out;
      end else begin
        checkOutput("hold_data", d, 32'(out), 32'(lastOut[d]));
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int d = 0; d < NDUT; d++) checkDut(d);
    end
  end

  initial begin
    rst       = 1'b1;
    wren_n    = 1'b1;
    oen_n     = 1'b1;
    be        = 2'b00;
    wraddress = '0;
    rdaddress = '0;
    data_in   = '0;
    for (int a = 0; a < NWORDS; a++) refMem[a] = 'x;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int a = 0; a < NWORDS; a++) applyStimulus(1'b1, 2'b11, a, DW'($urandom), 1'b0, 0);

    applyStimulus(1'b1, 2'b11, 5, 16'hBEEF, 1'b0, 0);
    applyStimulus(1'b0, 2'b00, 0, 16'h0000, 1'b1, 5);

    applyStimulus(1'b1, 2'b11, 7, 16'h1234, 1'b0, 0);
    applyStimulus(1'b1, 2'b01, 7, 16'hABCD, 1'b0, 0);
    applyStimulus(1'b0, 2'b00, 0, 16'h0000, 1'b1, 7);

    applyStimulus(1'b1, 2'b11, 3, 16'h0001, 1'b0, 0);
    applyStimulus(1'b1, 2'b11, 3, 16'h00FF, 1'b1, 3);
    applyStimulus(1'b0, 2'b00, 0, 16'h0000, 1'b1, 3);

    applyStimulus(1'b0, 2'b00, 0, 16'h0000, 1'b1, 0);
    applyStimulus(1'b0, 2'b00, 0, 16'h0000, 1'b1, 1);
    applyStimulus(1'b0, 2'b00, 0, 16'h0000, 1'b1, 2);

    applyStimulus(1'b1, 2'b00, 4, 16'hDEAD, 1'b1, 4);
    applyStimulus(1'b1, 2'b11, 6, 16'h7777, 1'b1, 8);
    applyStimulus(1'b0, 2'b00, 0, 16'h0000, 1'b1, 4);

    applyStimulus(1'b1, 2'b11, 9, 16'h5A5A, 1'b0, 0);
    applyStimulus(1'b0, 2'b00, 0, 16'h0000, 1'b1, 9);
    rst = 1'b1;
    flushQueues();
    applyStimulus(1'b1, 2'b11, 9, 16'hFFFF, 1'b1, 9);
    rst = 1'b0;
    applyStimulus(1'b0, 2'b00, 0, 16'h0000, 1'b0, 0);
    applyStimulus(1'b0, 2'b00, 0, 16'h0000, 1'b1, 9);

    for (int n = 0; n < 300; n++) begin
      applyStimulus(1'($urandom), 2'($urandom), int'($urandom_range(NWORDS - 1)), DW'($urandom),
                    1'($urandom), int'($urandom_range(NWORDS - 1)));
    end

    for (int k = 0; k < 10 && (expQ[0].size() > 0 || expQ[1].size() > 0); k++) @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      while (expQ[d].size() > 0) begin
        void'(expQ[d].pop_front());
        checkOutput("drain_timeout", d, 32'd0, 32'd1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
